ahb2apb_bridge: RTL and testbench

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/apb_rd_mux.sv | 30 +++
 rtl/ahb2apb_bridge.sv | 159 +++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: AHB encodings and bridge states.
package ahb_pkg;

    // AHB transfer types (HTRANS)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB response encodings (HRESP)
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Bridge control states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } bridge_state_e;

endpackage

// File: rtl/apb_rd_mux.sv
// Selects the addressed APB slave's read data, ready and error signals.
module apb_rd_mux #(
    parameter int NPSLV = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic [32*NPSLV-1:0]  prdata,
    input  logic [NPSLV-1:0]     pready,
    input  logic [NPSLV-1:0]     pslverr,
    output logic [31:0]          sel_prdata,
    output logic                 sel_pready,
    output logic                 sel_pslverr
);

    // An index with no slave behind it completes at once with an error,
    // so the bridge can never hang on an unmapped slot.
    always_comb begin
        sel_prdata  = '0;
        sel_pready  = 1'b1;
        sel_pslverr = 1'b1;
        for (int i = 0; i < NPSLV; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_prdata  = prdata[32*i +: 32];
                sel_pready  = pready[i];
                sel_pslverr = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB access per AHB transfer,
// HADDR[13:12] picks the APB slave, errors reported as a two-cycle response.
module ahb2apb_bridge
    import ahb_pkg::*;
#(
    parameter int NPSLV   = 4,
    parameter int PADDR_W = 16
) (
    input  logic                 HCLK,
    input  logic                 HRST,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic [1:0]           HRESP,
    output logic [31:0]          HRDATA,
    output logic [PADDR_W-1:0]   PADDR,
    output logic [NPSLV-1:0]     PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [32*NPSLV-1:0]  PRDATA,
    input  logic [NPSLV-1:0]     PREADY,
    input  logic [NPSLV-1:0]     PSLVERR
);

    localparam int IDX_W = (NPSLV > 1) ? $clog2(NPSLV) : 1;

    bridge_state_e       state_q, state_d;
    logic [PADDR_W-1:0]  paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic [31:0]         hrdata_q, hrdata_d;

    logic                sample;
    logic [31:0]         sel_prdata;
    logic                sel_pready;
    logic                sel_pslverr;

    // HSIZE is ignored (all APB accesses are 32-bit); only the low address
    // bits and HTRANS[1] carry meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{HSIZE, HADDR, HTRANS};

    apb_rd_mux #(
        .NPSLV (NPSLV),
        .IDX_W (IDX_W)
    ) u_rd_mux (
        .idx         (idx_q),
        .prdata      (PRDATA),
        .pready      (PREADY),
        .pslverr     (PSLVERR),
        .sel_prdata  (sel_prdata),
        .sel_pready  (sel_pready),
        .sel_pslverr (sel_pslverr)
    );

    // A NONSEQ/SEQ transfer is accepted only while the bridge shows ready.
    always_comb begin
        sample = HSEL && HREADY && HTRANS[1] &&
                 (state_q inside {ST_IDLE, ST_RESP, ST_ERR2});
    end

    // Next-state logic plus address, write-data and read-data capture.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        case (state_q)
            ST_IDLE, ST_RESP, ST_ERR2: state_d = sample ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                // HWDATA is valid in the AHB data phase, i.e. during WAIT.
                state_d  = ST_SETUP;
                pwdata_d = HWDATA;
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_pready) begin
                    state_d = sel_pslverr ? ST_ERR1 : ST_RESP;
                    if (!pwrite_q) begin
                        hrdata_d = sel_prdata;
                    end
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase

        if (sample) begin
            paddr_d  = HADDR[PADDR_W-1:0];
            pwrite_d = HWRITE;
            idx_d    = HADDR[12 +: IDX_W];
        end
    end

    // State and datapath registers; reset aborts any APB access at once.
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Bus-facing control outputs decoded from the state alone.
    always_comb begin
        PSEL      = '0;
        PENABLE   = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                for (int i = 0; i < NPSLV; i++) begin
                    PSEL[i] = (idx_q == IDX_W'(i));
                end
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                PENABLE   = 1'b1;
                for (int i = 0; i < NPSLV; i++) begin
                    PSEL[i] = (idx_q == IDX_W'(i));
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;
    assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: table of single transfers plus
// hand-written back-to-back, idle-transfer and mid-access reset sequences.
module tb_ahb2apb_bridge;

    localparam int NPSLV   = 4;
    localparam int PADDR_W = 16;

    logic                 HCLK = 1'b0;
    logic                 HRST;
    logic                 HSEL;
    logic [31:0]          HADDR;
    logic                 HWRITE;
    logic [1:0]           HTRANS;
    logic [2:0]           HSIZE;
    logic [31:0]          HWDATA;
    logic                 HREADY;
    logic                 HREADYOUT;
    logic [1:0]           HRESP;
    logic [31:0]          HRDATA;
    logic [PADDR_W-1:0]   PADDR;
    logic [NPSLV-1:0]     PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [31:0]          PWDATA;
    logic [32*NPSLV-1:0]  PRDATA;
    logic [NPSLV-1:0]     PREADY;
    logic [NPSLV-1:0]     PSLVERR;

    int checks = 0;
    int errors = 0;

    // Slave model controls
    int          cur_slave = 0;
    int          cur_wait  = 0;
    logic        cur_err   = 1'b0;
    logic [31:0] cur_rdata = '0;
    int          acc_cnt   = 0;

    ahb2apb_bridge #(.NPSLV(NPSLV), .PADDR_W(PADDR_W)) dut (
        .HCLK(HCLK), .HRST(HRST), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    // Only slave on the bus: bus-wide HREADY follows the bridge.
    assign HREADY = HREADYOUT;

    // Counts ACCESS cycles so the addressed slave can insert wait states.
    always @(posedge HCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    // Non-addressed slaves answer ready-with-error and junk data, so using
    // the wrong slave's signals shows up as a wrong response.
    always_comb begin
        for (int i = 0; i < NPSLV; i++) begin
            PREADY[i]          = 1'b1;
            PSLVERR[i]         = 1'b1;
            PRDATA[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
        end
        PREADY[cur_slave]          = (acc_cnt >= cur_wait);
        PSLVERR[cur_slave]         = cur_err;
        PRDATA[32*cur_slave +: 32] = cur_rdata;
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          slv;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  exp_psel;
        logic [15:0] exp_paddr;
        int          exp_low;
        logic [1:0]  exp_hresp;
        logic        chk_rd;
        logic [31:0] exp_hrdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = '0;
        HWRITE = 1'b0;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = 3'b010;
    endtask

    // Called at the negedge inside WAIT; returns at the first ready negedge.
    task automatic collect(output int low, output logic [3:0] psel,
                           output logic [15:0] paddr, output logic pwr,
                           output logic [31:0] pwd, output int errlow);
        low = 0; psel = '0; paddr = '0; pwr = 1'b0; pwd = '0; errlow = 0;
        for (int c = 0; c < 40 && HREADYOUT !== 1'b1; c++) begin
            low++;
            if (PSEL != '0 && !PENABLE) begin
                psel = PSEL; paddr = PADDR; pwr = PWRITE;
            end
            if (PENABLE) pwd = PWDATA;
            if (HRESP == 2'b01) errlow++;
            @(negedge HCLK);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int          low, errlow;
        logic [3:0]  psel;
        logic [15:0] paddr;
        logic        pwr;
        logic [31:0] pwd;
        @(negedge HCLK);
        cur_slave = v.slv; cur_wait = v.waits; cur_err = v.err; cur_rdata = v.rdata;
        drive_addr(v.addr, v.wr);
        @(negedge HCLK);
        drive_idle();
        HWDATA = v.wdata;
        collect(low, psel, paddr, pwr, pwd, errlow);
        chk($sformatf("v%0d done", n), 32'(HREADYOUT), 32'd1);
        chk($sformatf("v%0d wait_cycles", n), 32'(low), 32'(v.exp_low));
        chk($sformatf("v%0d psel", n), 32'(psel), 32'(v.exp_psel));
        chk($sformatf("v%0d paddr", n), 32'(paddr), 32'(v.exp_paddr));
        chk($sformatf("v%0d pwrite", n), 32'(pwr), 32'(v.wr));
        if (v.wr) chk($sformatf("v%0d pwdata", n), pwd, v.wdata);
        chk($sformatf("v%0d err1_cycles", n), 32'(errlow), v.err ? 32'd1 : 32'd0);
        chk($sformatf("v%0d hresp", n), 32'(HRESP), 32'(v.exp_hresp));
        if (v.chk_rd) chk($sformatf("v%0d hrdata", n), HRDATA, v.exp_hrdata);
    endtask

    initial begin
        vec_t rv;
        HRST = 1'b1; HWDATA = '0; HSIZE = 3'b010;
        drive_idle();

        vecs[0] = '{addr:32'h0000_1004, wr:1'b1, wdata:32'hDEADBEEF, slv:1, waits:0, err:1'b0,
                    rdata:32'h0, exp_psel:4'b0010, exp_paddr:16'h1004, exp_low:3,
                    exp_hresp:2'b00, chk_rd:1'b1, exp_hrdata:32'h0};
        vecs[1] = '{addr:32'h0000_3010, wr:1'b0, wdata:32'h0, slv:3, waits:2, err:1'b0,
                    rdata:32'h12345678, exp_psel:4'b1000, exp_paddr:16'h3010, exp_low:5,
                    exp_hresp:2'b00, chk_rd:1'b1, exp_hrdata:32'h12345678};
        vecs[2] = '{addr:32'h0000_2000, wr:1'b1, wdata:32'hA5A5A5A5, slv:2, waits:0, err:1'b1,
                    rdata:32'h0, exp_psel:4'b0100, exp_paddr:16'h2000, exp_low:4,
                    exp_hresp:2'b01, chk_rd:1'b1, exp_hrdata:32'h12345678};
        vecs[3] = '{addr:32'h0000_0008, wr:1'b0, wdata:32'h0, slv:0, waits:1, err:1'b0,
                    rdata:32'hCAFEF00D, exp_psel:4'b0001, exp_paddr:16'h0008, exp_low:4,
                    exp_hresp:2'b00, chk_rd:1'b1, exp_hrdata:32'hCAFEF00D};
        vecs[4] = '{addr:32'hFFFF_3FFC, wr:1'b1, wdata:32'h01234567, slv:3, waits:0, err:1'b0,
                    rdata:32'h0, exp_psel:4'b1000, exp_paddr:16'h3FFC, exp_low:3,
                    exp_hresp:2'b00, chk_rd:1'b1, exp_hrdata:32'hCAFEF00D};
        vecs[5] = '{addr:32'h0000_1010, wr:1'b0, wdata:32'h0, slv:1, waits:1, err:1'b1,
                    rdata:32'h55AA55AA, exp_psel:4'b0010, exp_paddr:16'h1010, exp_low:5,
                    exp_hresp:2'b01, chk_rd:1'b0, exp_hrdata:32'h0};

        // Reset state
        #12;
        chk("rst hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst hresp", 32'(HRESP), 32'd0);
        chk("rst hrdata", HRDATA, 32'd0);
        chk("rst psel", 32'(PSEL), 32'd0);
        chk("rst penable", 32'(PENABLE), 32'd0);
        chk("rst pwrite", 32'(PWRITE), 32'd0);
        chk("rst paddr", 32'(PADDR), 32'd0);
        chk("rst pwdata", PWDATA, 32'd0);
        @(negedge HCLK);
        HRST = 1'b0;

        // Table of single transfers
        for (int n = 0; n < 6; n++) run_vec(vecs[n], n);
        @(negedge HCLK);
        drive_idle();

        // IDLE / BUSY transfers with HSEL high: zero-wait OKAY, no APB access
        for (int t = 0; t < 2; t++) begin
            @(negedge HCLK);
            HSEL = 1'b1; HADDR = 32'h0000_1000; HWRITE = 1'b1;
            HTRANS = (t == 0) ? 2'b00 : 2'b01;
            for (int c = 0; c < 2; c++) begin
                @(negedge HCLK);
                chk($sformatf("htrans%0d psel c%0d", t, c), 32'(PSEL), 32'd0);
                chk($sformatf("htrans%0d hreadyout c%0d", t, c), 32'(HREADYOUT), 32'd1);
                chk($sformatf("htrans%0d hresp c%0d", t, c), 32'(HRESP), 32'd0);
            end
        end
        drive_idle();

        // Back-to-back reads: second address phase sampled in RESP
        begin
            int          low, errlow;
            logic [3:0]  psel;
            logic [15:0] paddr;
            logic        pwr;
            logic [31:0] pwd;
            @(negedge HCLK);
            cur_slave = 0; cur_wait = 0; cur_err = 1'b0; cur_rdata = 32'h11110000;
            drive_addr(32'h0000_0000, 1'b0);
            @(negedge HCLK);
            drive_idle();
            collect(low, psel, paddr, pwr, pwd, errlow);
            chk("b2b first wait_cycles", 32'(low), 32'd3);
            chk("b2b first hrdata", HRDATA, 32'h11110000);
            cur_slave = 1; cur_rdata = 32'h22221111;
            drive_addr(32'h0000_1000, 1'b0);
            @(negedge HCLK);
            drive_idle();
            chk("b2b wait hreadyout", 32'(HREADYOUT), 32'd0);
            chk("b2b wait psel", 32'(PSEL), 32'd0);
            @(negedge HCLK);
            chk("b2b setup psel", 32'(PSEL), 32'b0010);
            chk("b2b setup penable", 32'(PENABLE), 32'd0);
            chk("b2b setup paddr", 32'(PADDR), 32'h1000);
            @(negedge HCLK);
            chk("b2b access penable", 32'(PENABLE), 32'd1);
            @(negedge HCLK);
            chk("b2b resp hreadyout", 32'(HREADYOUT), 32'd1);
            chk("b2b second hrdata", HRDATA, 32'h22221111);
        end

        // Reset asserted during ACCESS
        @(negedge HCLK);
        cur_slave = 2; cur_wait = 5; cur_err = 1'b0; cur_rdata = '0;
        drive_addr(32'h0000_2000, 1'b1);
        @(negedge HCLK);
        drive_idle();
        HWDATA = 32'h77778888;
        for (int c = 0; c < 10 && PENABLE !== 1'b1; c++) @(negedge HCLK);
        chk("rstmid in access", 32'(PENABLE), 32'd1);
        #2 HRST = 1'b1;
        #1;
        chk("rstmid psel", 32'(PSEL), 32'd0);
        chk("rstmid penable", 32'(PENABLE), 32'd0);
        chk("rstmid hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rstmid hresp", 32'(HRESP), 32'd0);
        chk("rstmid pwdata", PWDATA, 32'd0);
        @(negedge HCLK);
        HRST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            chk($sformatf("rstmid idle psel c%0d", c), 32'(PSEL), 32'd0);
            chk($sformatf("rstmid idle hreadyout c%0d", c), 32'(HREADYOUT), 32'd1);
        end

        // Recovery transfer after reset
        rv = '{addr:32'h0000_2004, wr:1'b0, wdata:32'h0, slv:2, waits:0, err:1'b0,
               rdata:32'h0BADF00D, exp_psel:4'b0100, exp_paddr:16'h2004, exp_low:3,
               exp_hresp:2'b00, chk_rd:1'b1, exp_hrdata:32'h0BADF00D};
        run_vec(rv, 6);
        @(negedge HCLK);
        drive_idle();
        @(negedge HCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
